// File: rtl/spi_bits_master.sv
// ---------------------------------------------------------------------------
// spi_bits_master
//   SPI master for the register-bit access protocol of the FPGA's SPI
//   bit-register slave.  Mode 3 (SCK idles high, MOSI launched on the
//   falling edge, MISO sampled on the rising edge), LSB first.
//   Frame: 15-bit byte address, 1 R/W bit (1 = read), then N data bits.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   cmd_valid/ready command handshake; transfer when both are high on a
//                   rising clk edge.  cmd_ready is high only in IDLE, and
//                   cmd_valid is ignored at all other times.
//   cmd_rw          1 = read, 0 = write
//   cmd_addr        15-bit byte address
//   cmd_len         data bit count N (0 = header only, clamped to DATA_W)
//   cmd_wdata       write data, bit 0 sent first
//   rsp_valid       one-cycle pulse when the frame is complete
//   rsp_rdata       read data (bit i = i-th received bit), held until the
//                   next accept; zero for writes and above bit N-1
//   busy            high from accept until rsp_valid
//   spi_cs          chip select, active low
//   spi_sck         SPI clock
//   spi_mosi        master -> slave data
//   spi_miso        slave -> master data (asynchronous)
//   dbg_state       current FSM state, for observation
// ---------------------------------------------------------------------------
module spi_bits_master #(
    parameter int HALF_DIV = 8,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [14:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [2:0]        dbg_state
);

    localparam int FRAME_W = 16 + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int DIV_W   = $clog2(HALF_DIV);
    localparam int IDX_W   = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t               state_q,     state_d;
    logic [DIV_W-1:0]     div_q,       div_d;
    logic [BIT_W-1:0]     bit_q,       bit_d;
    logic [BIT_W-1:0]     last_q,      last_d;
    logic                 rw_q,        rw_d;
    logic [FRAME_W-1:0]   shift_q,     shift_d;
    logic [DATA_W-1:0]    rdata_q,     rdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 cs_q,        cs_d;
    logic                 sck_q,       sck_d;
    logic                 mosi_q,      mosi_d;
    logic                 miso_s1_q,   miso_s2_q;

    logic                 tick;
    logic [LEN_W-1:0]     len_eff;
    logic [DATA_W-1:0]    data_sel;
    logic [IDX_W-1:0]     data_idx;

    // MISO comes from another clock domain; two flops before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            last_q      <= '0;
            rw_q        <= 1'b0;
            shift_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            cs_q        <= 1'b1;
            sck_q       <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            last_q      <= last_d;
            rw_q        <= rw_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
        end
    end

    always_comb begin
        tick     = (div_q == DIV_W'(HALF_DIV - 1));
        len_eff  = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
        // Reads put zeros on MOSI during the data phase.
        data_sel = cmd_rw ? '0 : cmd_wdata;
        data_idx = IDX_W'(bit_q - BIT_W'(16));

        state_d     = state_q;
        div_d       = div_q + DIV_W'(1);
        bit_d       = bit_q;
        last_d      = last_q;
        rw_d        = rw_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        cs_d        = cs_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;

        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                cs_d   = 1'b1;
                sck_d  = 1'b1;
                mosi_d = 1'b0;
                if (cmd_valid) begin
                    state_d = S_SETUP;
                    rw_d    = cmd_rw;
                    // Index of the final frame bit: 16 header bits + N data bits.
                    last_d  = BIT_W'(15) + BIT_W'(len_eff);
                    bit_d   = '0;
                    shift_d = {data_sel, cmd_rw, cmd_addr};
                    rdata_d = '0;
                    cs_d    = 1'b0;
                    mosi_d  = cmd_addr[0];
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_LOW;
                    div_d   = '0;
                    sck_d   = 1'b0;
                    mosi_d  = shift_q[0];
                end
            end
            S_LOW: begin
                if (tick) begin
                    state_d = S_HIGH;
                    div_d   = '0;
                    sck_d   = 1'b1;
                    // Sample on the same edge that raises SCK.
                    if (rw_q && (bit_q >= BIT_W'(16))) begin
                        rdata_d[data_idx] = miso_s2_q;
                    end
                end
            end
            S_HIGH: begin
                if (tick) begin
                    div_d = '0;
                    if (bit_q == last_q) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        sck_d   = 1'b0;
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        mosi_d  = shift_q[1];
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_d = S_GAP;
                    div_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d     = S_IDLE;
                    div_d       = '0;
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                cs_d    = 1'b1;
                sck_d   = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign spi_cs    = cs_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign dbg_state = state_q;

endmodule
